// File: rtl/spi_slave_burst.sv
// Multi-word SPI slave: all four SPI modes, unbounded bursts per chip-select window,
// pull-style transmit handshake, strobed receive. Optional macro: SPIS_BURST_SYNC_EN.
module spi_slave_burst #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    WCNT_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [WCNT_WIDTH-1:0] word_cnt,
    output logic                  busy
);

    localparam int                    BCNT_W    = $clog2(DATA_WIDTH);
    localparam logic [BCNT_W-1:0]     BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0]     BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);
    localparam logic [WCNT_WIDTH-1:0] WCNT_ONE  = WCNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    function automatic logic [WCNT_WIDTH-1:0] sat_inc(input logic [WCNT_WIDTH-1:0] v);
        return (&v) ? v : v + WCNT_ONE;
    endfunction

    logic w_sclk_in;
    logic w_csn_in;
    logic w_mosi_in;

`ifdef SPIS_BURST_SYNC_EN
    logic [1:0] r_sclk_sync;
    logic [1:0] r_csn_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sclk_sync <= 2'b00;
            r_csn_sync  <= 2'b11;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_csn_sync  <= {r_csn_sync[0], csn};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_sclk_in = r_sclk_sync[1];
    assign w_csn_in  = r_csn_sync[1];
    assign w_mosi_in = r_mosi_sync[1];
`else
    assign w_sclk_in = sclk;
    assign w_csn_in  = csn;
    assign w_mosi_in = mosi;
`endif

    // Edge-detect stage: _p0 is the current registered pin, _p1 its previous value
    logic r_sclk_p0;
    logic r_sclk_p1;
    logic r_csn_p0;
    logic r_csn_p1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sclk_p0 <= 1'b0;
            r_sclk_p1 <= 1'b0;
            r_csn_p0  <= 1'b1;
            r_csn_p1  <= 1'b1;
        end else begin
            r_sclk_p0 <= w_sclk_in;
            r_sclk_p1 <= r_sclk_p0;
            r_csn_p0  <= w_csn_in;
            r_csn_p1  <= r_csn_p0;
        end
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_cpol;
    logic                    r_cpha;
    logic [BCNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_sr;
    logic [DATA_WIDTH-2:0]   r_rx_sr;
    logic [DATA_WIDTH-1:0]   w_rx_word;
    logic                    r_load_pend;
    logic                    r_hold;
    logic                    r_rx_valid;
    logic                    r_frame_done;
    logic                    r_frame_err;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic [WCNT_WIDTH-1:0]   r_word_cnt;

    logic w_csn_fall;
    logic w_csn_rise;
    logic w_sclk_edge;
    logic w_lead;
    logic w_in_frame;
    logic w_sample;
    logic w_shift;
    logic w_last_bit;
    logic w_word_load;

    assign w_csn_fall  = r_csn_p1 & ~r_csn_p0;
    assign w_csn_rise  = ~r_csn_p1 & r_csn_p0;
    assign w_sclk_edge = r_sclk_p0 ^ r_sclk_p1;
    // A leading edge leaves the idle level, so the previous level equals cpol
    assign w_lead      = w_sclk_edge & (r_sclk_p1 == r_cpol);
    assign w_in_frame  = (r_state == ST_ACTIVE) & ~r_csn_p0;
    assign w_sample    = w_in_frame & w_sclk_edge & (r_cpha ? ~w_lead : w_lead);
    assign w_shift     = w_in_frame & w_sclk_edge & (r_cpha ? w_lead : ~w_lead);
    assign w_last_bit  = (r_bit_cnt == BCNT_LAST);
    assign w_rx_word   = {r_rx_sr, w_mosi_in};

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_ACTIVE;
                w_word_load = 1'b1;
            end
            ST_ACTIVE: begin
                if (w_csn_rise) begin
                    w_state_nxt = ST_DONE;
                end
                // cpha=1 reloads on the final sample; cpha=0 on the following shift edge
                if (r_cpha) begin
                    w_word_load = w_sample & w_last_bit;
                end else begin
                    w_word_load = w_shift & r_load_pend;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_bit_cnt    <= '0;
            r_tx_sr      <= '0;
            r_rx_sr      <= '0;
            r_load_pend  <= 1'b0;
            r_hold       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_data    <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            if (r_state == ST_LOAD) begin
                r_cpol      <= cpol;
                r_cpha      <= cpha;
                r_bit_cnt   <= '0;
                r_rx_sr     <= '0;
                r_word_cnt  <= '0;
            end

            if (w_word_load) begin
                r_tx_sr     <= tx_valid ? tx_data : TX_IDLE;
                r_hold      <= 1'b1;
                r_load_pend <= 1'b0;
            end else if (w_shift) begin
                // With cpha=1 the MSB is already on miso, so the first shift edge keeps it
                if (r_cpha && r_hold) begin
                    r_hold <= 1'b0;
                end else begin
                    r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                end
            end

            if (w_sample) begin
                r_rx_sr <= w_rx_word[DATA_WIDTH-2:0];
                if (w_last_bit) begin
                    r_rx_data   <= w_rx_word;
                    r_rx_valid  <= 1'b1;
                    r_word_cnt  <= sat_inc(r_word_cnt);
                    r_bit_cnt   <= '0;
                    r_load_pend <= ~r_cpha;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BCNT_ONE;
                end
            end

            if (r_state == ST_DONE) begin
                r_frame_done <= 1'b1;
                r_frame_err  <= (r_bit_cnt != '0);
            end
        end
    end

    assign miso        = (r_state == ST_ACTIVE) & r_tx_sr[DATA_WIDTH-1];
    assign miso_oe     = (r_state == ST_ACTIVE);
    assign busy        = (r_state == ST_LOAD) | (r_state == ST_ACTIVE);
    assign tx_ready    = w_word_load;
    assign tx_underrun = w_word_load & ~tx_valid;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: bit-banged SPI master in all four modes,
// pull-style tx feeder and a strobe monitor; expected values are hand-computed.
`timescale 1ns/1ps
module tb_spi_slave_burst;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       arstn;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] word_cnt;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave_burst #(
        .DATA_WIDTH(8),
        .WCNT_WIDTH(8),
        .TX_IDLE   (8'hFF)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .csn        (csn),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor
    int         rx_cnt  = 0;
    int         tr_cnt  = 0;
    int         un_cnt  = 0;
    int         fd_cnt  = 0;
    logic       fe_last = 1'b0;
    logic [7:0] rx_log [0:63];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt++;
        end
        if (tx_ready)    tr_cnt++;
        if (tx_underrun) un_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fe_last = frame_err;
        end
    end

    // Pull-style transmit feeder
    int         tx_pos  = 0;
    int         tx_base = 0;
    int         tx_n    = 0;
    bit         tx_en   = 1'b0;
    int         tx_idx_c;
    logic [7:0] txq [0:7];

    always @(posedge clk) begin
        if (tx_ready) tx_pos <= tx_pos + 1;
    end

    always_comb begin
        tx_idx_c = tx_pos - tx_base;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (tx_en && tx_idx_c >= 0 && tx_idx_c < tx_n && tx_idx_c < 8) begin
            tx_valid = 1'b1;
            tx_data  = txq[tx_idx_c];
        end
    end

    task automatic tx_setup(input bit en, input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        tx_en   = en;
        tx_n    = n;
        txq[0]  = d0;
        txq[1]  = d1;
        txq[2]  = d2;
        txq[3]  = d3;
        tx_base = tx_pos;
    endtask

    int b_rx, b_tr, b_un, b_fd;

    task automatic snap();
        b_rx = rx_cnt;
        b_tr = tr_cnt;
        b_un = un_cnt;
        b_fd = fd_cnt;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-banged SPI master
    logic [7:0] m_tx [0:7];
    logic [7:0] m_rx [0:7];
    logic       m_oe_seen;

    task automatic master_frame(input logic mc, input logic mh, input int nbits,
                                input bit end_frame, input bit toggle);
        int w;
        int i;
        cpol = mc;
        cpha = mh;
        sclk = mc;
        wait_clk(3);
        csn = 1'b0;
        wait_clk(4);
        if (toggle) begin
            cpol = ~mc;
            cpha = ~mh;
        end
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            i = 7 - (b % 8);
            if (!mh) begin
                mosi = m_tx[w][i];
                wait_clk(HALF);
                m_rx[w][i] = miso;
                if (b == 0) m_oe_seen = miso_oe & busy;
                sclk = ~mc;
                wait_clk(HALF);
                sclk = mc;
            end else begin
                sclk = ~mc;
                mosi = m_tx[w][i];
                wait_clk(HALF);
                m_rx[w][i] = miso;
                if (b == 0) m_oe_seen = miso_oe & busy;
                sclk = mc;
                wait_clk(HALF);
            end
        end
        if (end_frame) begin
            wait_clk(HALF);
            csn = 1'b1;
            wait_clk(8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] modes [0:3];

    initial begin
        arstn = 1'b0;
        csn   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        tx_setup(1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_clk(3);

        check_eq("rst_ctl", {miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_done, frame_err}, 8'h00);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_word_cnt", word_cnt, 8'h00);
        arstn = 1'b1;
        wait_clk(3);

        // Mode 0, single word
        tx_setup(1'b1, 2, 8'h3C, 8'h3C, 8'h00, 8'h00);
        m_tx[0] = 8'hA5;
        snap();
        master_frame(1'b0, 1'b0, 8, 1'b1, 1'b0);
        check_eq("m0_miso", m_rx[0], 8'h3C);
        check_eq("m0_oe_busy", m_oe_seen, 1'b1);
        check_eq("m0_rx_cnt", rx_cnt - b_rx, 1);
        check_eq("m0_rx_word", rx_log[b_rx % 64], 8'hA5);
        check_eq("m0_rx_data", rx_data, 8'hA5);
        check_eq("m0_frame_done", fd_cnt - b_fd, 1);
        check_eq("m0_frame_err", fe_last, 1'b0);
        check_eq("m0_word_cnt", word_cnt, 8'd1);
        check_eq("m0_tx_ready", tr_cnt - b_tr, 2);
        check_eq("m0_underrun", un_cnt - b_un, 0);
        check_eq("m0_idle", {busy, miso_oe, miso}, 3'b000);

        // Mode 3 burst of three words
        tx_setup(1'b1, 3, 8'hC1, 8'hC2, 8'hC3, 8'h00);
        m_tx[0] = 8'h11;
        m_tx[1] = 8'h22;
        m_tx[2] = 8'h33;
        snap();
        master_frame(1'b1, 1'b1, 24, 1'b1, 1'b0);
        check_eq("m3_miso0", m_rx[0], 8'hC1);
        check_eq("m3_miso1", m_rx[1], 8'hC2);
        check_eq("m3_miso2", m_rx[2], 8'hC3);
        check_eq("m3_rx_cnt", rx_cnt - b_rx, 3);
        check_eq("m3_rx0", rx_log[b_rx % 64], 8'h11);
        check_eq("m3_rx1", rx_log[(b_rx + 1) % 64], 8'h22);
        check_eq("m3_rx2", rx_log[(b_rx + 2) % 64], 8'h33);
        check_eq("m3_tx_ready", tr_cnt - b_tr, 4);
        check_eq("m3_underrun", un_cnt - b_un, 1);
        check_eq("m3_word_cnt", word_cnt, 8'd3);
        check_eq("m3_frame_err", fe_last, 1'b0);

        // Mode 1 with no transmit data available
        tx_setup(1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        m_tx[0] = 8'h5A;
        m_tx[1] = 8'h96;
        snap();
        master_frame(1'b0, 1'b1, 16, 1'b1, 1'b0);
        check_eq("m1_miso0", m_rx[0], 8'hFF);
        check_eq("m1_miso1", m_rx[1], 8'hFF);
        check_eq("m1_underrun", un_cnt - b_un, 3);
        check_eq("m1_tx_ready", tr_cnt - b_tr, 3);
        check_eq("m1_rx0", rx_log[b_rx % 64], 8'h5A);
        check_eq("m1_rx1", rx_log[(b_rx + 1) % 64], 8'h96);
        check_eq("m1_word_cnt", word_cnt, 8'd2);

        // Abort after 5 bits of the second word
        tx_setup(1'b1, 4, 8'h12, 8'h34, 8'h56, 8'h78);
        m_tx[0] = 8'h81;
        m_tx[1] = 8'h7E;
        snap();
        master_frame(1'b0, 1'b0, 13, 1'b1, 1'b0);
        check_eq("ab_rx_cnt", rx_cnt - b_rx, 1);
        check_eq("ab_rx_data", rx_data, 8'h81);
        check_eq("ab_word_cnt", word_cnt, 8'd1);
        check_eq("ab_frame_done", fd_cnt - b_fd, 1);
        check_eq("ab_frame_err", fe_last, 1'b1);

        // Reset asserted three bits into a frame
        tx_setup(1'b1, 4, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        m_tx[0] = 8'hF0;
        snap();
        master_frame(1'b0, 1'b0, 3, 1'b0, 1'b0);
        check_eq("rm_busy_before", busy, 1'b1);
        arstn = 1'b0;
        #1;
        check_eq("rm_ctl", {miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_done, frame_err}, 8'h00);
        check_eq("rm_rx_data", rx_data, 8'h00);
        check_eq("rm_word_cnt", word_cnt, 8'h00);
        csn = 1'b1;
        wait_clk(2);
        arstn = 1'b1;
        wait_clk(6);
        check_eq("rm_no_frame_done", fd_cnt - b_fd, 0);

        // Mode 2 frame after the reset
        tx_setup(1'b1, 2, 8'h42, 8'h42, 8'h00, 8'h00);
        m_tx[0] = 8'hE7;
        snap();
        master_frame(1'b1, 1'b0, 8, 1'b1, 1'b0);
        check_eq("m2_miso", m_rx[0], 8'h42);
        check_eq("m2_rx_data", rx_data, 8'hE7);
        check_eq("m2_word_cnt", word_cnt, 8'd1);
        check_eq("m2_frame_done", fd_cnt - b_fd, 1);
        check_eq("m2_frame_err", fe_last, 1'b0);

        // Mode sweep 0,3,1,2 with mode pins flipped mid-frame
        modes[0] = 2'd0;
        modes[1] = 2'd3;
        modes[2] = 2'd1;
        modes[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tx_setup(1'b1, 4, 8'h96, 8'h96, 8'h96, 8'h96);
            m_tx[0] = 8'h69;
            m_rx[0] = 8'h00;
            snap();
            master_frame(modes[k][1], modes[k][0], 8, 1'b1, 1'b1);
            check_eq($sformatf("sw%0d_rx_data", modes[k]), rx_data, 8'h69);
            check_eq($sformatf("sw%0d_miso", modes[k]), m_rx[0], 8'h96);
            check_eq($sformatf("sw%0d_rx_cnt", modes[k]), rx_cnt - b_rx, 1);
            check_eq($sformatf("sw%0d_frame_err", modes[k]), fe_last, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Multi-word SPI slave: the next generation of the project's single-word SPI slave. It runs all four SPI modes, selected at run time, and transfers an unbounded burst of DATA_WIDTH-bit words within one chip-select window. The user side has a pull-style transmit handshake and a strobed receive interface, plus frame status. It sits between the external SPI pins and user logic in the `clk` domain; the external master owns `sclk`.

## Interface
- DATA_WIDTH, 8: bits per word, ≥2.
- WCNT_WIDTH, 8: width of the per-frame word counter.
- TX_IDLE, {DATA_WIDTH{1'b1}}: word shifted out on transmit underrun.
- clk  in  1  system clock; must run at ≥4× `sclk` (≥6× with SPIS_BURST_SYNC_EN).
- arstn  in  1  asynchronous active-low reset.
- cpol, cpha  in  1 each  mode select; latched at frame start, ignored mid-frame.
- sclk, csn, mosi  in  1 each  SPI pins; `csn` is active low.
- miso  out  1  serial data out; 0 whenever not in ACTIVE.
- miso_oe  out  1  high in ACTIVE only, for an external tristate.
- tx_data  in  DATA_WIDTH  next word to send.
- tx_valid  in  1  `tx_data` is valid.
- tx_ready  out  1  one-cycle strobe marking a word-load point.
- tx_underrun  out  1  one-cycle strobe; TX_IDLE was loaded.
- rx_data  out  DATA_WIDTH  last complete received word; holds its value.
- rx_valid  out  1  one-cycle strobe; `rx_data` is updated in the same cycle.
- frame_done  out  1  one-cycle strobe at frame end.
- frame_err  out  1  qualifies `frame_done`: frame ended mid-word.
- word_cnt  out  WCNT_WIDTH  complete words received in the current or last frame.
- busy  out  1  high in LOAD and ACTIVE.

## Operation
- Edge detection: `sclk` and `csn` are registered and compared with their previous value. Only `sclk` edges seen in ACTIVE with `csn` low count.
- Edge roles: leading edge = transition away from the latched `cpol`.
  - `cpha=0`: sample on the leading edge, shift on the trailing edge.
  - `cpha=1`: shift on the leading edge, sample on the trailing edge.
- Bit order: MSB first in both directions. `miso` = tx_sr[DATA_WIDTH-1].
- FSM states: IDLE, LOAD, ACTIVE, DONE.
  - IDLE → LOAD on a `csn` falling edge.
  - LOAD (1 cycle): latch `cpol`/`cpha`, clear the counters and `word_cnt`, perform a word-load, go to ACTIVE.
  - ACTIVE → DONE on a `csn` rising edge; otherwise stay in ACTIVE.
  - DONE (1 cycle): pulse `frame_done`, with `frame_err` = (bit_cnt≠0). Then go to IDLE.
- Word-load: `tx_ready` pulses for one cycle.
  - If `tx_valid` is high in that cycle, tx_sr ← `tx_data`.
  - Otherwise tx_sr ← TX_IDLE and `tx_underrun` pulses in the same cycle.
- Sample edge: rx_sr ← {rx_sr, mosi}; bit_cnt increments. When bit_cnt reaches DATA_WIDTH:
  - `rx_data` ← the completed word and `rx_valid` pulses.
  - `word_cnt` increments, saturating at all-ones.
  - bit_cnt ← 0.
- Shift edge:
  - `cpha=0`: the shift edge after the DATA_WIDTH-th sample of a word performs a word-load instead of a shift. All other shift edges shift tx_sr left.
  - `cpha=1`: the first shift edge of each word holds tx_sr, since its MSB is already driven. The DATA_WIDTH-th sample edge performs the word-load for the next word.
- Aborted word: if `csn` rises mid-word, the partial rx_sr is discarded. `rx_data` and `word_cnt` are unchanged.
- `tx_data` is not consumed on an abort. A word-load that has already occurred counts as consumed.
- No receive backpressure: the user must take `rx_data` within DATA_WIDTH `sclk` periods.

## Timing
- Reset values: all outputs 0 except `rx_data` = 0 and `word_cnt` = 0. FSM in IDLE, registered `sclk` = 0, registered `csn` = 1.
- Reset asserted mid-frame: everything returns to reset values immediately. No `frame_done` is produced. The block waits for the next `csn` falling edge.
- Latency from a pin edge to its effect: 1 `clk` (2 registers deep), or 3 `clk` with SPIS_BURST_SYNC_EN.
- `rx_valid`: 1 cycle after the detected final sample edge of a word.
- `frame_done`: 2 cycles after the `csn` rise is detected.
- First `miso` bit is valid 2 cycles after the `csn` fall is detected. The master must allow ≥3 `clk` (≥5 with the macro) between `csn` falling and the first `sclk` edge.
- A `csn` falling edge in DONE is ignored. The master must hold `csn` high ≥3 `clk` between frames.

## Configuration
- SPIS_BURST_SYNC_EN defined: `sclk`, `csn` and `mosi` each pass through a 2-flop synchronizer before edge detection and sampling. This adds 2 cycles of latency.
- SPIS_BURST_SYNC_EN undefined: single-register edge detection on `sclk`/`csn`; `mosi` is sampled raw. Use only when the pins are already synchronous to `clk`.

## Test plan
- Mode 0, one word: tx_data=0x3C held valid, master sends 0xA5. Required: `miso` carries 0x3C, `rx_data`=0xA5 with one `rx_valid`, `frame_done`=1, `frame_err`=0, `word_cnt`=1.
- Mode 3 burst: master sends 0x11,0x22,0x33, tx supplies 0xC1,0xC2,0xC3. Required: three `rx_valid` strobes carrying the words in order, 3 `tx_ready` strobes plus a 4th unused load, `word_cnt`=3.
- Mode 1 underrun: `tx_valid` low throughout, TX_IDLE=0xFF. Required: `miso`=0xFF, one `tx_underrun` per word-load, `rx_data` still correct.
- Abort: `csn` rises after 5 bits of the second word. Required: `word_cnt`=1, `rx_data` = first word, `frame_done` with `frame_err`=1.
- Reset mid-frame: pull `arstn` low after 3 bits. Required: all outputs return to reset values and no `frame_done`. A following mode 2 frame then transfers correctly.
- Mode switch between frames (0→3→1→2) with the same data. Required: identical `rx_data` each time. Toggling `cpol`/`cpha` mid-frame has no effect.
